// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix datapath.
//   rtr_state_t  : operand router FSM states
//   DATA_W_DEF   : default operand beat width
//   K_MAX_DEF    : largest inner dimension supported by router and compute stage
//   cfg_k_legal  : true when a requested K lies in 1..k_max
package matmul_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int K_MAX_DEF  = 64;

  typedef enum logic [1:0] {
    RTR_IDLE    = 2'd0,
    RTR_ROUTE_A = 2'd1,
    RTR_ROUTE_B = 2'd2,
    RTR_DRAIN   = 2'd3
  } rtr_state_t;

  function automatic logic cfg_k_legal(input logic [15:0] k, input int k_max);
    return (k != 16'd0) && (int'(k) <= k_max);
  endfunction

endpackage

// File: rtl/operand_stream_router_if.sv
// AXI-Stream style bundle used for the router's input frame and both
// operand output streams.
//   tdata/tvalid/tlast : driven by the master
//   tready             : driven by the slave
interface operand_stream_router_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer for a stream carrying tdata + tlast.
// One cycle from input handshake to output valid, one beat per cycle under
// continuous ready, and an input ready that depends only on local state.
//   clk, rst          : clock, asynchronous active-high reset
//   i_in_tdata/tlast  : incoming beat
//   i_in_tvalid       : incoming beat valid
//   o_in_tready       : buffer can take a beat this cycle
//   o_out_tdata/tlast : head beat, stable while stalled
//   o_out_tvalid      : head beat valid
//   i_out_tready      : downstream accepts head beat
module axis_skid_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_in_tdata,
  input  logic              i_in_tlast,
  input  logic              i_in_tvalid,
  output logic              o_in_tready,
  output logic [DATA_W-1:0] o_out_tdata,
  output logic              o_out_tlast,
  output logic              o_out_tvalid,
  input  logic              i_out_tready
);

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_out_vld;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_last;
  logic              r_skid_vld;
  logic              w_in_fire;
  logic              w_out_free;

  // Ready comes only from the skid slot, so it never sees downstream ready.
  assign o_in_tready = !r_skid_vld;
  assign w_in_fire   = i_in_tvalid && !r_skid_vld;
  assign w_out_free  = !r_out_vld || i_out_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_vld   <= 1'b0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
      r_skid_vld  <= 1'b0;
    end else if (w_out_free) begin
      // Head slot empties this cycle: refill from skid first to keep order.
      if (r_skid_vld) begin
        r_out_data <= r_skid_data;
        r_out_last <= r_skid_last;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_in_fire) begin
        r_out_data <= i_in_tdata;
        r_out_last <= i_in_tlast;
        r_out_vld  <= 1'b1;
      end else begin
        r_out_vld  <= 1'b0;
      end
    end else if (w_in_fire) begin
      // Head is stalled: park the new beat in the skid slot.
      r_skid_data <= i_in_tdata;
      r_skid_last <= i_in_tlast;
      r_skid_vld  <= 1'b1;
    end
  end

  assign o_out_tdata  = r_out_data;
  assign o_out_tlast  = r_out_last;
  assign o_out_tvalid = r_out_vld;

endmodule

// File: rtl/operand_stream_router.sv
// Splits one operand frame (A: 2xK row-major, then B: Kx2 row-major, 4K
// beats) into separate A and B streams with per-matrix tlast, and checks
// frame length against K with sticky error bits.
//   clk, rst   : clock, asynchronous active-high reset
//   s_axis     : operand frame in (slave)
//   m_axis_a   : A operand stream out (master)
//   m_axis_b   : B operand stream out (master)
//   cfg_k      : inner dimension, latched when a frame is armed
//   start      : arm for one frame, sampled only when idle
//   busy       : FSM not idle
//   frame_done : one-cycle pulse after the last B beat is taken
//   err_cfg    : sticky, start seen with K out of 1..K_MAX
//   err_len    : sticky, input tlast early or missing
//   err_clr    : clears both error bits; a same-cycle set wins
module operand_stream_router
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K_MAX  = K_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  operand_stream_router_if.slave  s_axis,
  operand_stream_router_if.master m_axis_a,
  operand_stream_router_if.master m_axis_b,
  input  logic [15:0]             cfg_k,
  input  logic                    start,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_cfg,
  output logic                    err_len,
  input  logic                    err_clr
);

  localparam int CNT_W = $clog2(2 * K_MAX) + 1;

  rtr_state_t       r_state;
  rtr_state_t       w_state_nxt;
  logic [15:0]      r_k_q;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_beat_cnt_nxt;
  logic             r_frame_done;
  logic             r_err_cfg;
  logic             r_err_len;

  logic             w_latch_k;
  logic             w_set_err_cfg;
  logic             w_set_err_len;
  logic             w_frame_done_nxt;
  logic             w_s_tready;
  logic             w_a_in_valid;
  logic             w_b_in_valid;
  logic             w_a_in_ready;
  logic             w_b_in_ready;
  logic [16:0]      w_last_idx;
  logic             w_is_last;
  logic             w_fwd_tlast;

  // 2*K-1 at 17 bits so K up to 16 bits never wraps.
  assign w_last_idx  = {r_k_q, 1'b0} - 17'd1;
  assign w_is_last   = (17'(r_beat_cnt) == w_last_idx);
  // An early input tlast closes whichever matrix is currently being routed.
  assign w_fwd_tlast = w_is_last || s_axis.tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RTR_IDLE;
      r_k_q        <= '0;
      r_beat_cnt   <= '0;
      r_frame_done <= 1'b0;
      r_err_cfg    <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (w_latch_k) r_k_q <= cfg_k;
      if (w_set_err_cfg)  r_err_cfg <= 1'b1;
      else if (err_clr)   r_err_cfg <= 1'b0;
      if (w_set_err_len)  r_err_len <= 1'b1;
      else if (err_clr)   r_err_len <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_latch_k        = 1'b0;
    w_set_err_cfg    = 1'b0;
    w_set_err_len    = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_s_tready       = 1'b0;
    w_a_in_valid     = 1'b0;
    w_b_in_valid     = 1'b0;
    case (r_state)
      RTR_IDLE: begin
        if (start) begin
          if (cfg_k_legal(cfg_k, K_MAX)) begin
            w_latch_k      = 1'b1;
            w_beat_cnt_nxt = '0;
            w_state_nxt    = RTR_ROUTE_A;
          end else begin
            w_set_err_cfg  = 1'b1;
          end
        end
      end
      RTR_ROUTE_A: begin
        w_s_tready   = w_a_in_ready;
        w_a_in_valid = s_axis.tvalid;
        if (s_axis.tvalid && w_a_in_ready) begin
          if (s_axis.tlast) begin
            w_set_err_len  = 1'b1;
            w_beat_cnt_nxt = '0;
            w_state_nxt    = RTR_IDLE;
          end else if (w_is_last) begin
            w_beat_cnt_nxt = '0;
            w_state_nxt    = RTR_ROUTE_B;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          end
        end
      end
      RTR_ROUTE_B: begin
        w_s_tready   = w_b_in_ready;
        w_b_in_valid = s_axis.tvalid;
        if (s_axis.tvalid && w_b_in_ready) begin
          if (w_is_last) begin
            w_frame_done_nxt = 1'b1;
            w_beat_cnt_nxt   = '0;
            if (s_axis.tlast) begin
              w_state_nxt   = RTR_IDLE;
            end else begin
              w_set_err_len = 1'b1;
              w_state_nxt   = RTR_DRAIN;
            end
          end else if (s_axis.tlast) begin
            w_set_err_len  = 1'b1;
            w_beat_cnt_nxt = '0;
            w_state_nxt    = RTR_IDLE;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          end
        end
      end
      RTR_DRAIN: begin
        // Surplus beats are swallowed until the frame's own tlast.
        w_s_tready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) w_state_nxt = RTR_IDLE;
      end
      default: w_state_nxt = RTR_IDLE;
    endcase
  end

  assign s_axis.tready = w_s_tready;
  assign busy          = (r_state != RTR_IDLE);
  assign frame_done    = r_frame_done;
  assign err_cfg       = r_err_cfg;
  assign err_len       = r_err_len;

  axis_skid_buffer #(.DATA_W(DATA_W)) u_skid_a (
    .clk          (clk),
    .rst          (rst),
    .i_in_tdata   (s_axis.tdata),
    .i_in_tlast   (w_fwd_tlast),
    .i_in_tvalid  (w_a_in_valid),
    .o_in_tready  (w_a_in_ready),
    .o_out_tdata  (m_axis_a.tdata),
    .o_out_tlast  (m_axis_a.tlast),
    .o_out_tvalid (m_axis_a.tvalid),
    .i_out_tready (m_axis_a.tready)
  );

  axis_skid_buffer #(.DATA_W(DATA_W)) u_skid_b (
    .clk          (clk),
    .rst          (rst),
    .i_in_tdata   (s_axis.tdata),
    .i_in_tlast   (w_fwd_tlast),
    .i_in_tvalid  (w_b_in_valid),
    .o_in_tready  (w_b_in_ready),
    .o_out_tdata  (m_axis_b.tdata),
    .o_out_tlast  (m_axis_b.tlast),
    .o_out_tvalid (m_axis_b.tvalid),
    .i_out_tready (m_axis_b.tready)
  );

endmodule
